ripple_count_reader: RTL and testbench

// - Synchronous reader for a free-running asynchronous ripple counter (each bit

---
 rtl/ripple_count_reader_if.sv | 24 ++
 rtl/ripple_count_reader.sv | 105 ++++++++++
 tb/tb_ripple_count_reader.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ripple_count_reader_if.sv
// Bus between a ripple-counter sampler and its synchronous consumer.
// The master drives the raw counter bits and the clear; the slave returns the accepted results.
interface ripple_count_reader_if #(
    parameter int W  = 4,
    parameter int TW = 16
);
    logic [W-1:0]  cnt_in;
    logic          clr;
    logic [W-1:0]  value;
    logic [W-1:0]  delta;
    logic          upd;
    logic [TW-1:0] total;
    logic          unstable;

    modport master (
        output cnt_in, clr,
        input  value, delta, upd, total, unstable
    );

    modport slave (
        input  cnt_in, clr,
        output value, delta, upd, total, unstable
    );
endinterface

// File: rtl/ripple_count_reader.sv
// Samples a free-running asynchronous ripple counter and accepts a value only once it has been stable.
// Each accepted value produces a modulo step (delta) and advances a wide running total.
module ripple_count_reader #(
    parameter int W       = 4,
    parameter int TW      = 16,
    parameter int STABLE  = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ripple_count_reader_if.slave  bus
);
    localparam int RW = (STABLE  < 1) ? 1 : $clog2(STABLE + 1);
    localparam int IW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic {
        SETTLING,
        LOCKED
    } state_t;

    state_t        state;
    logic [W-1:0]  sync1;
    logic [W-1:0]  sync2;
    logic [W-1:0]  prev;
    logic [RW-1:0] run;
    logic [IW-1:0] idle;
    logic [W-1:0]  value;
    logic [W-1:0]  delta;
    logic          upd;
    logic [TW-1:0] total;
    logic          unstable;

    logic          same;
    logic [RW-1:0] run_next;
    logic          lock_now;
    logic [W-1:0]  delta_new;

    always_comb begin
        same     = (sync2 == prev);
        run_next = '0;
        if (same) begin
            if (run == RW'(STABLE)) begin
                run_next = run;
            end else begin
                run_next = run + 1'b1;
            end
        end
        // Lock on the very edge the run counter reaches STABLE.
        lock_now  = (state == SETTLING) && (run_next == RW'(STABLE));
        delta_new = sync2 - value;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SETTLING;
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            run      <= '0;
            idle     <= '0;
            value    <= '0;
            delta    <= '0;
            upd      <= 1'b0;
            total    <= '0;
            unstable <= 1'b0;
        end else begin
            sync1 <= bus.cnt_in;
            sync2 <= sync1;
            prev  <= sync2;
            run   <= run_next;
            upd   <= 1'b0;

            if (lock_now) begin
                state <= LOCKED;
                if (sync2 != value) begin
                    value <= sync2;
                    delta <= delta_new;
                    total <= total + TW'(delta_new);
                    upd   <= 1'b1;
                end
            end else if ((state == LOCKED) && !same) begin
                state <= SETTLING;
            end

            if (state == LOCKED) begin
                idle <= '0;
            end else if (idle != IW'(TIMEOUT)) begin
                idle <= idle + 1'b1;
            end

            // A coincident clear loses to a fresh timeout.
            if (idle == IW'(TIMEOUT)) begin
                unstable <= 1'b1;
            end else if (bus.clr) begin
                unstable <= 1'b0;
            end
        end
    end

    assign bus.value    = value;
    assign bus.delta    = delta;
    assign bus.upd      = upd;
    assign bus.total    = total;
    assign bus.unstable = unstable;
endmodule

// File: tb/tb_ripple_count_reader.sv
// Directed bench for ripple_count_reader with hand-computed expectations (W=4, TW=16, STABLE=2, TIMEOUT=16).
module tb_ripple_count_reader;
    localparam int W       = 4;
    localparam int TW      = 16;
    localparam int STABLE  = 2;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;
    int   upd_seen = 0;

    always #5 clk = ~clk;

    ripple_count_reader_if #(.W(W), .TW(TW)) bus ();

    ripple_count_reader #(
        .W(W), .TW(TW), .STABLE(STABLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.upd) upd_seen++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.cnt_in = '0;
        bus.clr    = 1'b0;
        #12;
        check("rst_upd",      32'(bus.upd),      0);
        check("rst_value",    32'(bus.value),    0);
        check("rst_delta",    32'(bus.delta),    0);
        check("rst_total",    32'(bus.total),    0);
        check("rst_unstable", 32'(bus.unstable), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Zero held: nothing to accept
        upd_seen = 0;
        ticks(50);
        check("idle_upd_count", 32'(upd_seen),     0);
        check("idle_value",     32'(bus.value),    0);
        check("idle_total",     32'(bus.total),    0);
        check("idle_unstable",  32'(bus.unstable), 0);

        // 0 -> 1: upd appears exactly after the 5th edge (edge k+4)
        bus.cnt_in = 4'd1;
        upd_seen = 0;
        ticks(4);
        check("lat_early_upd", 32'(upd_seen), 0);
        tick();
        check("lat_upd",   32'(bus.upd),   1);
        check("lat_value", 32'(bus.value), 1);
        check("lat_delta", 32'(bus.delta), 1);
        check("lat_total", 32'(bus.total), 1);
        tick();
        check("lat_upd_pulse", 32'(bus.upd), 0);
        ticks(5);
        check("lat_upd_count", 32'(upd_seen), 1);

        // 1 -> 7 held
        bus.cnt_in = 4'd7;
        ticks(10);
        check("seven_value", 32'(bus.value), 7);
        check("seven_delta", 32'(bus.delta), 6);
        check("seven_total", 32'(bus.total), 7);

        // Ripple 7 -> 6 -> 4 -> 0 -> 8, one cycle each, then 8 held
        upd_seen = 0;
        bus.cnt_in = 4'd6; tick();
        bus.cnt_in = 4'd4; tick();
        bus.cnt_in = 4'd0; tick();
        bus.cnt_in = 4'd8;
        ticks(10);
        check("ripple_upd_count", 32'(upd_seen),  1);
        check("ripple_value",     32'(bus.value), 8);
        check("ripple_delta",     32'(bus.delta), 1);
        check("ripple_total",     32'(bus.total), 8);

        // 8 -> 15, then wrap 15 -> 1
        bus.cnt_in = 4'd15;
        ticks(10);
        check("f_value", 32'(bus.value), 15);
        check("f_delta", 32'(bus.delta), 7);
        check("f_total", 32'(bus.total), 15);
        upd_seen = 0;
        bus.cnt_in = 4'd1;
        ticks(10);
        check("wrap_upd_count", 32'(upd_seen),  1);
        check("wrap_value",     32'(bus.value), 1);
        check("wrap_delta",     32'(bus.delta), 2);
        check("wrap_total",     32'(bus.total), 17);

        // Toggle 2/3 every cycle for 20 cycles, then hold 3
        upd_seen = 0;
        for (int i = 0; i < 10; i++) begin
            bus.cnt_in = (i % 2 == 1) ? 4'd3 : 4'd2;
            tick();
        end
        check("toggle_mid_unstable", 32'(bus.unstable), 0);
        for (int i = 10; i < 20; i++) begin
            bus.cnt_in = (i % 2 == 1) ? 4'd3 : 4'd2;
            tick();
        end
        bus.cnt_in = 4'd3;
        ticks(10);
        check("toggle_unstable",  32'(bus.unstable), 1);
        check("toggle_upd_count", 32'(upd_seen),     1);
        check("toggle_value",     32'(bus.value),    3);
        check("toggle_delta",     32'(bus.delta),    2);
        check("toggle_total",     32'(bus.total),    19);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        ticks(5);
        check("clr_unstable", 32'(bus.unstable), 0);

        // Reset while settling, then release with 5 held
        bus.cnt_in = 4'd9;
        ticks(3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_value",    32'(bus.value),    0);
        check("mid_rst_delta",    32'(bus.delta),    0);
        check("mid_rst_total",    32'(bus.total),    0);
        check("mid_rst_upd",      32'(bus.upd),      0);
        check("mid_rst_unstable", 32'(bus.unstable), 0);
        ticks(2);
        bus.cnt_in = 4'd5;
        rst_n = 1'b1;
        upd_seen = 0;
        ticks(10);
        check("post_rst_upd_count", 32'(upd_seen),     1);
        check("post_rst_value",     32'(bus.value),    5);
        check("post_rst_delta",     32'(bus.delta),    5);
        check("post_rst_total",     32'(bus.total),    5);
        check("post_rst_unstable",  32'(bus.unstable), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
